// File: rtl/hwpe_ctrl_reqrsp_arbiter.sv
// Round-robin arbiter that lets several reqrsp initiators share one target
// port, with at most one outstanding transaction (request, then response).
`timescale 1ns/1ps

module hwpe_ctrl_reqrsp_arbiter #(
    parameter int unsigned NB_REQ = 2,
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    // initiator-side request channel, initiator 0 in the LSBs
    input  logic [NB_REQ-1:0]            in_q_valid_i,
    output logic [NB_REQ-1:0]            in_q_ready_o,
    input  logic [NB_REQ*AW-1:0]         in_q_addr_i,
    input  logic [NB_REQ-1:0]            in_q_write_i,
    input  logic [NB_REQ*DW-1:0]         in_q_data_i,
    input  logic [NB_REQ*(DW/8)-1:0]     in_q_strb_i,
    // initiator-side response channel, data broadcast
    output logic [NB_REQ-1:0]            in_p_valid_o,
    input  logic [NB_REQ-1:0]            in_p_ready_i,
    output logic [DW-1:0]                in_p_data_o,
    // shared target port
    output logic                         out_q_valid_o,
    input  logic                         out_q_ready_i,
    output logic [AW-1:0]                out_q_addr_o,
    output logic                         out_q_write_o,
    output logic [DW-1:0]                out_q_data_o,
    output logic [DW/8-1:0]              out_q_strb_o,
    input  logic                         out_p_valid_i,
    output logic                         out_p_ready_o,
    input  logic [DW-1:0]                out_p_data_i,
    // status
    output logic [NB_REQ-1:0]            grant_o,
    output logic                         busy_o
);

    localparam int unsigned SW    = DW / 8;
    localparam int unsigned IDXW  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int unsigned IDXW1 = IDXW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e              r_state;
    logic [IDXW-1:0]     r_gnt_idx;
    logic [IDXW-1:0]     r_rr_ptr;
    logic [NB_REQ-1:0]   r_grant;
    logic                r_busy;

    logic [IDXW-1:0]     w_arb_idx;
    logic                w_arb_found;
    logic [IDXW:0]       w_sum;
    logic                w_gnt_q_valid;
    logic                w_q_hs;
    logic                w_p_hs;
    logic [IDXW-1:0]     w_ptr_next;

    // Pick the first valid initiator at or above the round-robin pointer, wrapping.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_sum       = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + IDXW1'(i);
            if (w_sum >= IDXW1'(NB_REQ)) begin
                w_sum = w_sum - IDXW1'(NB_REQ);
            end
            if (!w_arb_found && in_q_valid_i[IDXW'(w_sum)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = IDXW'(w_sum);
            end
        end
    end

    // Route the granted initiator to the target port; everything else idles at 0.
    always_comb begin
        out_q_valid_o = 1'b0;
        out_q_addr_o  = '0;
        out_q_write_o = 1'b0;
        out_q_data_o  = '0;
        out_q_strb_o  = '0;
        in_q_ready_o  = '0;
        in_p_valid_o  = '0;
        out_p_ready_o = 1'b0;
        w_gnt_q_valid = 1'b0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (r_gnt_idx == IDXW'(i)) begin
                if (r_state == ST_REQ) begin
                    w_gnt_q_valid   = in_q_valid_i[i];
                    out_q_valid_o   = in_q_valid_i[i];
                    out_q_addr_o    = in_q_addr_i[i*AW +: AW];
                    out_q_write_o   = in_q_write_i[i];
                    out_q_data_o    = in_q_data_i[i*DW +: DW];
                    out_q_strb_o    = in_q_strb_i[i*SW +: SW];
                    in_q_ready_o[i] = out_q_ready_i;
                end
                if (r_state == ST_RSP) begin
                    in_p_valid_o[i] = out_p_valid_i;
                    out_p_ready_o   = in_p_ready_i[i];
                end
            end
        end
    end

    assign in_p_data_o = out_p_data_i;
    assign w_q_hs      = out_q_valid_o & out_q_ready_i;
    assign w_p_hs      = out_p_valid_i & out_p_ready_o;
    assign w_ptr_next  = (r_gnt_idx == IDXW'(NB_REQ - 1)) ? '0 : r_gnt_idx + IDXW'(1);
    assign grant_o     = r_grant;
    assign busy_o      = r_busy;

    // Transaction FSM: arbitrate, forward request, wait for response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
        end else if (clear_i) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_arb_found) begin
                        r_state   <= ST_REQ;
                        r_gnt_idx <= w_arb_idx;
                        r_grant   <= NB_REQ'(1) << w_arb_idx;
                        r_busy    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_q_hs) begin
                        r_state <= ST_RSP;
                    end else if (!w_gnt_q_valid) begin
                        // initiator withdrew: abort without moving the pointer
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RSP: begin
                    if (w_p_hs) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_ptr_next;
                        r_grant  <= '0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
